// File: rtl/mskaes_32bits_key_loader_pkg.sv
// -----------------------------------------------------------------------------
// mskaes_32bits_key_loader_pkg
// Shared AES definitions: key-size codes, the words-per-key lookup, the key
// column count and the loader FSM states. The key datapath's rcon mode decode
// uses the same key-size codes.
// -----------------------------------------------------------------------------
package mskaes_32bits_key_loader_pkg;

    // Number of 32-bit key columns held (enough for AES-256).
    localparam int N_COLS = 8;
    // Width of the word counter (addresses 0..N_COLS-1).
    localparam int CNT_W  = 3;

    typedef enum logic [1:0] {
        KS_128 = 2'b00,
        KS_192 = 2'b01,
        KS_256 = 2'b10,
        KS_RSV = 2'b11
    } key_size_e;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_HOLD = 1'b1
    } ld_state_e;

    // The reserved code is handled as AES-128.
    function automatic key_size_e sanitize_size(input logic [1:0] code);
        key_size_e ks;
        ks = (code == KS_RSV) ? KS_128 : key_size_e'(code);
        return ks;
    endfunction

    // Number of 32-bit words that make up a key of the given size.
    function automatic logic [3:0] nwords_of(input key_size_e ks);
        logic [3:0] n;
        case (ks)
            KS_192:  n = 4'd6;
            KS_256:  n = 4'd8;
            default: n = 4'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mskaes_32bits_key_loader_ctrl.sv
// -----------------------------------------------------------------------------
// mskaes_32bits_key_loader_ctrl
// LOAD/HOLD FSM, 3-bit word counter and key-size latch of the key loader.
//   clk, rst     : clock, synchronous active-high reset
//   in_valid     : a key word is offered
//   in_key_size  : size code, only looked at for word 0
//   key_ready    : consumer takes the held key
//   in_ready     : registered, high in LOAD
//   key_valid    : registered, high in HOLD
//   key_size     : latched (sanitised) size code
//   size_err     : one-cycle pulse after a reserved code was sampled
//   col_we       : per-column write enable
//   col_zero     : per-column select of the zero sharing instead of the word
// -----------------------------------------------------------------------------
module mskaes_32bits_key_loader_ctrl
    import mskaes_32bits_key_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [1:0]        in_key_size,
    input  logic              key_ready,
    output logic              in_ready,
    output logic              key_valid,
    output logic [1:0]        key_size,
    output logic              size_err,
    output logic [N_COLS-1:0] col_we,
    output logic [N_COLS-1:0] col_zero
);

    ld_state_e        state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    key_size_e        key_size_q,  key_size_d;
    logic             in_ready_q,  in_ready_d;
    logic             key_valid_q, key_valid_d;
    logic             size_err_q,  size_err_d;

    logic             first;
    key_size_e        size_eff;
    logic [3:0]       nwords;

    // NOTE: every signal assigned here gets a default before any branch, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        key_size_d  = key_size_q;
        in_ready_d  = in_ready_q;
        key_valid_d = key_valid_q;
        size_err_d  = 1'b0;
        col_we      = '0;
        col_zero    = '0;

        // Word 0 decides the key length; later words use the latched size.
        first    = (cnt_q == '0);
        size_eff = first ? sanitize_size(in_key_size) : key_size_q;
        nwords   = nwords_of(size_eff);

        case (state_q)
            ST_LOAD: begin
                if (in_valid) begin
                    if (first) begin
                        key_size_d = size_eff;
                        size_err_d = (in_key_size == KS_RSV);
                    end
                    // Word goes to column cnt; on word 0 every column past the
                    // key length is cleared in the same cycle so no stale shares
                    // from a longer previous key survive.
                    for (int k = 0; k < N_COLS; k++) begin
                        if (k == int'(cnt_q)) begin
                            col_we[k] = 1'b1;
                        end else if (first && (k >= int'(nwords))) begin
                            col_we[k]   = 1'b1;
                            col_zero[k] = 1'b1;
                        end
                    end
                    if ({1'b0, cnt_q} == (nwords - 4'd1)) begin
                        state_d     = ST_HOLD;
                        cnt_d       = '0;
                        in_ready_d  = 1'b0;
                        key_valid_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (key_ready) begin
                    state_d     = ST_LOAD;
                    in_ready_d  = 1'b1;
                    key_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments only, so all flops
    // see the pre-edge values of each other regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_LOAD;
            cnt_q       <= '0;
            key_size_q  <= KS_128;
            in_ready_q  <= 1'b1;
            key_valid_q <= 1'b0;
            size_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            key_size_q  <= key_size_d;
            in_ready_q  <= in_ready_d;
            key_valid_q <= key_valid_d;
            size_err_q  <= size_err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign key_valid = key_valid_q;
    assign key_size  = key_size_q;
    assign size_err  = size_err_q;

endmodule

// File: rtl/mskaes_32bits_key_loader_reg.sv
// -----------------------------------------------------------------------------
// mskaes_32bits_key_loader_reg
// Masked enabled register: holds 'count' shared bits (count*d wires), loading
// in_data when en is high. Shares pass straight through; nothing combines them.
//   clk, rst  : clock, synchronous active-high reset (clears to all-zero shares)
//   en        : load enable
//   in_data   : shared input, count*d bits
//   out_data  : shared registered output, count*d bits
// -----------------------------------------------------------------------------
module mskaes_32bits_key_loader_reg #(
    parameter int count = 32,
    parameter int d     = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [count*d-1:0] in_data,
    output logic [count*d-1:0] out_data
);

    logic [count*d-1:0] data_q;
    logic [count*d-1:0] data_d;

    always_comb begin
        data_d = en ? in_data : data_q;
    end

    // NOTE: key storage is reset on purpose: a cleared loader must never
    // expose a previous key's shares, so these flops are not left reset-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign out_data = data_q;

endmodule

// File: rtl/mskaes_32bits_key_loader.sv
// -----------------------------------------------------------------------------
// mskaes_32bits_key_loader
// Assembles a d-share masked AES key (128/192/256 bit) from 32-bit shared
// words and holds it for the key datapath until it is consumed.
//   clk, rst     : clock, synchronous active-high reset
//   in_valid     : word present          in_ready  : word accepted this cycle
//   in_sh_word   : 32*d shared word, byte b at [8*d*b +: 8*d], shares
//                  interleaved per bit
//   in_key_size  : 00/01/10 = AES-128/192/256, 11 reserved (used as 00)
//   sh_key       : 256*d shared key, column k at [32*d*k +: 32*d]
//   key_size     : latched size code     key_valid : complete key held
//   key_ready    : consumer takes key    size_err  : reserved-code pulse
// -----------------------------------------------------------------------------
module mskaes_32bits_key_loader
    import mskaes_32bits_key_loader_pkg::*;
#(
    parameter int d = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [32*d-1:0]  in_sh_word,
    input  logic [1:0]       in_key_size,
    output logic [256*d-1:0] sh_key,
    output logic [1:0]       key_size,
    output logic             key_valid,
    input  logic             key_ready,
    output logic             size_err
);

    localparam int W = 32 * d;

    logic [N_COLS-1:0] col_we;
    logic [N_COLS-1:0] col_zero;

    mskaes_32bits_key_loader_ctrl u_ctrl (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_key_size (in_key_size),
        .key_ready   (key_ready),
        .in_ready    (in_ready),
        .key_valid   (key_valid),
        .key_size    (key_size),
        .size_err    (size_err),
        .col_we      (col_we),
        .col_zero    (col_zero)
    );

    // One masked register per key column. The zero constant is a valid
    // sharing of 0, selected share-wise; shares are never combined.
    for (genvar k = 0; k < N_COLS; k++) begin : g_col
        logic [W-1:0] col_in;

        assign col_in = col_zero[k] ? '0 : in_sh_word;

        mskaes_32bits_key_loader_reg #(
            .count (32),
            .d     (d)
        ) u_col_reg (
            .clk      (clk),
            .rst      (rst),
            .en       (col_we[k]),
            .in_data  (col_in),
            .out_data (sh_key[W*k +: W])
        );
    end

endmodule

// File: tb/tb_mskaes_32bits_key_loader.sv
// -----------------------------------------------------------------------------
// tb_mskaes_32bits_key_loader
// Table-driven bench for the masked key loader (d = 2). Each record loads one
// key; expected columns come from a small column model kept by the bench.
// -----------------------------------------------------------------------------
module tb_mskaes_32bits_key_loader;

    localparam int D = 2;
    localparam int W = 32 * D;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_sh_word;
    logic [1:0]       in_key_size;
    logic [256*D-1:0] sh_key;
    logic [1:0]       key_size;
    logic             key_valid;
    logic             key_ready;
    logic             size_err;

    always #5 clk = ~clk;

    mskaes_32bits_key_loader #(.d(D)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sh_word  (in_sh_word),
        .in_key_size (in_key_size),
        .sh_key      (sh_key),
        .key_size    (key_size),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .size_err    (size_err)
    );

    typedef struct {
        logic [1:0]  size;      // code driven with word 0
        int          nsend;     // words making up the key
        logic [1:0]  exp_size;  // expected latched code
        logic        exp_err;   // expected size_err pulse
        logic [31:0] salt;      // varies the word values between loads
    } vec_t;

    vec_t         vecs [5];
    logic [W-1:0] exp_col [8];
    int           total = 0;
    int           bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Two-share sharing of v with mask m, shares interleaved per bit.
    function automatic logic [W-1:0] share2(input logic [31:0] v, input logic [31:0] m);
        logic [W-1:0] r;
        for (int i = 0; i < 32; i++) begin
            r[2*i]   = v[i] ^ m[i];
            r[2*i+1] = m[i];
        end
        return r;
    endfunction

    task automatic check_cols(input string tag);
        for (int c = 0; c < 8; c++) begin
            check($sformatf("%s col%0d", tag, c), 64'(sh_key[W*c +: W]), 64'(exp_col[c]));
        end
    endtask

    task automatic check_reset_state(input string tag);
        for (int c = 0; c < 8; c++) exp_col[c] = '0;
        check({tag, " in_ready"},  64'(in_ready),  64'(1));
        check({tag, " key_valid"}, 64'(key_valid), 64'(0));
        check({tag, " key_size"},  64'(key_size),  64'(0));
        check({tag, " size_err"},  64'(size_err),  64'(0));
        check_cols(tag);
    endtask

    // Back-to-back load of one key; key_ready is pulsed during word 1 and
    // later words carry a different size code, both of which must be ignored.
    task automatic load_key(input vec_t v, input string tag);
        logic [W-1:0] words [8];
        logic [31:0]  val;
        int           ready_cycles;
        ready_cycles = 0;
        for (int k = 0; k < v.nsend; k++) begin
            val      = (32'h1111_1111 * (k + 1)) ^ v.salt;
            words[k] = share2(val, $urandom());
            if (in_ready) ready_cycles++;
            check($sformatf("%s w%0d in_ready", tag, k),  64'(in_ready),  64'(1));
            check($sformatf("%s w%0d key_valid", tag, k), 64'(key_valid), 64'(0));
            in_valid    = 1'b1;
            in_sh_word  = words[k];
            in_key_size = (k == 0) ? v.size : ~v.size;
            key_ready   = (k == 1);
            tick();
            if (k == 0) check({tag, " size_err pulse"}, 64'(size_err), 64'(v.exp_err));
            if (k == 1) check({tag, " size_err after"}, 64'(size_err), 64'(0));
        end
        in_valid   = 1'b0;
        key_ready  = 1'b0;
        in_sh_word = '0;
        for (int c = 0; c < 8; c++) exp_col[c] = (c < v.nsend) ? words[c] : '0;
        check({tag, " ready cycles"}, 64'(ready_cycles), 64'(v.nsend));
        check({tag, " key_valid"},    64'(key_valid),    64'(1));
        check({tag, " in_ready low"}, 64'(in_ready),     64'(0));
        check({tag, " key_size"},     64'(key_size),     64'(v.exp_size));
        check_cols(tag);
    endtask

    task automatic consume(input string tag);
        key_ready = 1'b1;
        tick();
        key_ready = 1'b0;
        check({tag, " consume in_ready"},  64'(in_ready),  64'(1));
        check({tag, " consume key_valid"}, 64'(key_valid), 64'(0));
        check_cols({tag, " kept"});
    endtask

    task automatic hold_test();
        for (int i = 0; i < 5; i++) begin
            in_valid   = 1'b1;
            in_sh_word = {$urandom(), $urandom()};
            tick();
            check($sformatf("hold c%0d in_ready", i),  64'(in_ready),  64'(0));
            check($sformatf("hold c%0d key_valid", i), 64'(key_valid), 64'(1));
        end
        in_valid   = 1'b0;
        in_sh_word = '0;
        check_cols("hold");
    endtask

    initial begin
        vecs[0] = '{size: 2'b00, nsend: 4, exp_size: 2'b00, exp_err: 1'b0, salt: 32'h0000_0000};
        vecs[1] = '{size: 2'b10, nsend: 8, exp_size: 2'b10, exp_err: 1'b0, salt: 32'hA5A5_0F0F};
        vecs[2] = '{size: 2'b00, nsend: 4, exp_size: 2'b00, exp_err: 1'b0, salt: 32'h0000_FFFF};
        vecs[3] = '{size: 2'b11, nsend: 4, exp_size: 2'b00, exp_err: 1'b1, salt: 32'h1234_5678};
        vecs[4] = '{size: 2'b01, nsend: 6, exp_size: 2'b01, exp_err: 1'b0, salt: 32'hDEAD_BEEF};

        rst         = 1'b1;
        in_valid    = 1'b0;
        key_ready   = 1'b0;
        in_key_size = 2'b00;
        in_sh_word  = '0;
        tick();
        tick();
        rst = 1'b0;
        check_reset_state("reset");

        for (int i = 0; i < 5; i++) begin
            load_key(vecs[i], $sformatf("v%0d", i));
            if (i == 0) hold_test();
            consume($sformatf("v%0d", i));
        end

        // Reset after 3 of 6 words, colliding with a transfer and key_ready.
        for (int k = 0; k < 3; k++) begin
            in_valid    = 1'b1;
            in_key_size = 2'b01;
            in_sh_word  = share2(32'hCAFE_0000 + k, $urandom());
            tick();
        end
        check("partial no key_valid", 64'(key_valid), 64'(0));
        rst        = 1'b1;
        key_ready  = 1'b1;
        in_sh_word = {$urandom(), $urandom()};
        tick();
        rst       = 1'b0;
        in_valid  = 1'b0;
        key_ready = 1'b0;
        check_reset_state("midload rst");

        load_key('{size: 2'b00, nsend: 4, exp_size: 2'b00, exp_err: 1'b0, salt: 32'h5A5A_5A5A}, "after rst");
        consume("after rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mskaes_32bits_key_loader.md
MSKAES_32BITS_KEY_LOADER -- requirements
Module: MSKaes_32bits_key_loader

Interface
REQ-001 The block SHALL have parameter d, default 2, meaning the number of shares per bit.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: a shared key word is present.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block accepts a word this cycle.
REQ-006 The block SHALL have port in_sh_word, input, 32*d bits: one shared key column, byte b at [8*d*b +: 8*d], share-interleaved per bit.
REQ-007 The block SHALL have port in_key_size, input, 2 bits: 00=AES-128, 01=AES-192, 10=AES-256, 11=reserved; sampled with the first word only.
REQ-008 The block SHALL have port sh_key, output, 256*d bits: assembled shared key, column k at [32*d*k +: 32*d], ready for the key datapath's sh_key input.
REQ-009 The block SHALL have port key_size, output, 2 bits: latched size code of the held key.
REQ-010 The block SHALL have port key_valid, output, 1 bit: a complete key is held.
REQ-011 The block SHALL have port key_ready, input, 1 bit: the consumer takes the key (asserted together with its init).
REQ-012 The block SHALL have port size_err, output, 1 bit: one-cycle pulse when a reserved size code is sampled.

Function
REQ-013 The block SHALL implement two states: LOAD (in_ready=1, key_valid=0) and HOLD (in_ready=0, key_valid=1).
REQ-014 In LOAD, an in_valid&in_ready transfer SHALL write in_sh_word into column cnt and increment the 3-bit word counter cnt.
REQ-015 On the first transfer (cnt=0), the block SHALL latch in_key_size into key_size and set nwords = 4/6/8 for codes 00/01/10.
REQ-016 On the first transfer, the block SHALL write zero sharings (all shares 0) into every column index >= nwords in the same cycle.
REQ-017 A reserved code 11 SHALL be treated as 00 (nwords=4, key_size=00) and SHALL pulse size_err for exactly the cycle after the transfer.
REQ-018 The transfer with cnt = nwords-1 SHALL move the FSM to HOLD and clear cnt to 0; key_valid SHALL rise the next cycle.
REQ-019 In HOLD, sh_key and key_size SHALL remain bit-stable, and in_valid SHALL be ignored (no write, no counter change).
REQ-020 In HOLD, key_valid&key_ready SHALL return the FSM to LOAD on the next cycle; sh_key SHALL keep its contents until overwritten by new transfers.
REQ-021 key_ready asserted while in LOAD SHALL have no effect.
REQ-022 The handshake SHALL be zero-bubble: a transfer is accepted on every in_valid cycle in LOAD, so 4/6/8 consecutive valid cycles complete a 128/192/256-bit key.
REQ-023 in_ready SHALL depend only on state (registered), never combinationally on in_valid or key_ready.
REQ-024 Shares SHALL never be recombined; the datapath SHALL be registers and share-wise muxes only, with no XOR across shares.

Reset
REQ-025 When rst=1 at a clock edge, the block SHALL set state=LOAD, cnt=0, key_size=00, key_valid=0 and size_err=0, and SHALL zero all 256*d sh_key bits.
REQ-026 After reset, in_ready SHALL be 1 from the first cycle after rst deasserts.
REQ-027 Reset mid-load SHALL discard the partial key; the next transfer SHALL be treated as word 0 with a fresh size sample.
REQ-028 Reset SHALL take priority over a simultaneous transfer or key_ready.

Structure
REQ-029 The key-size codes, the nwords lookup (4/6/8) and the column count (8) SHALL live in the shared AES package, common with the key datapath's rcon mode decode.
REQ-030 The FSM, counter and size latch SHALL be one sub-module, MSKaes_key_loader_ctrl, outputting per-column write enables and zero-fill selects.
REQ-031 Column storage SHALL be 8 instances of the existing masked enabled register (count=32), each with a share-wise mux selecting in_sh_word or a zero constant.

Verification
REQ-032 Verification SHALL cover this scenario: reset, then 4 words with size=00 and word k = 0x11111111*(k+1) shares -> key_valid after the 4th; columns 0-3 hold the words, columns 4-7 are all-zero, key_size=00.
REQ-033 Verification SHALL cover this scenario: 8 back-to-back words with size=10 -> exactly 8 cycles with in_ready=1, key_valid=1 on cycle 9, all 8 columns correct.
REQ-034 Verification SHALL cover this scenario: a 256-bit key is loaded and consumed, then a 128-bit key is loaded -> columns 4-7 read zero, with no stale 256-bit data.
REQ-035 Verification SHALL cover this scenario: in HOLD, in_valid=1 for 5 cycles with random data -> sh_key unchanged and in_ready=0; key_ready=1 for 1 cycle -> in_ready=1 the next cycle.
REQ-036 Verification SHALL cover this scenario: rst asserted after 3 of 6 words (size=01) -> all outputs at reset values; a following 4-word size=00 load completes normally.
REQ-037 Verification SHALL cover this scenario: size=11 on the first word -> size_err for 1 cycle, key_size=00, and key_valid after 4 words.
